// File: rtl/bram_tree_pq_pkg.sv
// Shared types for the level-per-memory priority queue.
// Holds the op encoding, the controller state set and the priority compare.
// No logic or storage lives here.
package bram_tree_pq_pkg;

  typedef enum logic [1:0] {
    NOP     = 2'b00,
    PUSH    = 2'b01,
    POP     = 2'b10,
    REPLACE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_LAST,
    RD,
    WR,
    DONE
  } state_e;

  // Strict priority: a ties with b is never better, so existing nodes keep their place.
  function automatic logic better(input logic is_max, input logic [63:0] a, input logic [63:0] b);
    return is_max ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/bram_tree_pq_if.sv
// Request/status bundle between a scheduler front end and the priority queue.
// master: drives i_valid/i_op/i_data, observes i_ready and the o_* status.
// slave: the queue side of the same signals.
interface bram_tree_pq_if #(
  parameter int DataWidth  = 32,
  parameter int CountWidth = 4
);
  import bram_tree_pq_pkg::*;

  logic                  i_valid;
  op_e                   i_op;
  logic [DataWidth-1:0]  i_data;
  logic                  i_ready;
  logic [DataWidth-1:0]  o_data;
  logic                  o_top_valid;
  logic [CountWidth-1:0] o_count;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_err;

  modport master (
    output i_valid, i_op, i_data,
    input  i_ready, o_data, o_top_valid, o_count, o_full, o_empty, o_err
  );

  modport slave (
    input  i_valid, i_op, i_data,
    output i_ready, o_data, o_top_valid, o_count, o_full, o_empty, o_err
  );
endinterface

// File: rtl/bram_tree_pq_level_ram.sv
// One tree level: Depth nodes stored as sibling pairs (even/odd halves).
// Latency: registered read, 1 cycle; read-during-write returns old data.
// Ports: single-node write (waddr = node offset), pair read (raddr = pair index).
module bram_tree_pq_level_ram
  import bram_tree_pq_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 2,
  parameter int AW        = 5
) (
  input  logic                 CLK,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [DataWidth-1:0] rd_lo,
  output logic [DataWidth-1:0] rd_hi
);
  localparam int PAW = (Depth > 2) ? $clog2(Depth) - 1 : 1;

  logic [DataWidth-1:0] mem_lo [2**PAW];
  logic [DataWidth-1:0] mem_hi [2**PAW];
  logic [PAW-1:0]       wpair;
  logic [PAW-1:0]       rpair;
  logic                 unused_addr;

  assign wpair       = waddr[PAW:1];
  assign rpair       = raddr[PAW-1:0];
  // Address buses are shared across levels; the upper bits belong to deeper levels.
  assign unused_addr = ^{waddr[AW-1:PAW+1], raddr[AW-1:PAW]};

  always_ff @(posedge CLK) begin
    if (we) begin
      if (waddr[0]) mem_hi[wpair] <= wdata;
      else          mem_lo[wpair] <= wdata;
    end
    rd_lo <= mem_lo[rpair];
    rd_hi <= mem_hi[rpair];
  end
endmodule

// File: rtl/bram_tree_pq.sv
// Heap-ordered priority queue, one memory per tree level; o_data is the best item.
// Latency: push/pop/replace busy at most 2*TreeDepth+2 cycles; nop and illegal ops take none.
// Backpressure: i_ready low while an op walks the tree; status only changes in DONE.
// Ports: CLK, RST (sync, active high), bus = bram_tree_pq_if.slave.
module bram_tree_pq
  import bram_tree_pq_pkg::*;
#(
  parameter int QueueSize = 8,
  parameter int DataWidth = 32,
  parameter bit IsMax     = 1'b1,
  parameter int TreeDepth = $clog2(QueueSize + 1)
) (
  input logic           CLK,
  input logic           RST,
  bram_tree_pq_if.slave bus
);
  localparam int CW = $clog2(QueueSize + 1);
  localparam int IW = TreeDepth + 1;  // holds child index 2n+1 of any stored node

  state_e               state_q, state_d;
  logic [IW-1:0]        cur_q, cur_d, tgt_q, tgt_d, sl_q, sl_d;
  logic [DataWidth-1:0] v_q, v_d, root_q, root_d, top_q, top_d;
  logic [CW-1:0]        cnt_q, cnt_d, wcnt_q, wcnt_d;
  logic                 push_q, push_d, fetch_q, fetch_d, err_q, err_d;

  logic [IW-1:0]          ram_raddr, ram_waddr;
  logic [DataWidth-1:0]   ram_wdat;
  logic [TreeDepth-1:1]   ram_we;
  logic [DataWidth-1:0]   rd_lo [TreeDepth];
  logic [DataWidth-1:0]   rd_hi [TreeDepth];

  logic                 wr_go;
  logic [IW-1:0]        wr_node, left, right, best, wcnt_x;
  logic [DataWidth-1:0] wr_val, nv, lval, rval, bval;
  int                   lt, lc, ls, cl;

  function automatic int lev(input logic [IW-1:0] n);
    int r;
    r = 0;
    for (int i = 0; i < IW; i++) if (n[i]) r = i;
    return r;
  endfunction

  function automatic logic [IW-1:0] off(input logic [IW-1:0] n);
    return n & ~(IW'(1) << lev(n));
  endfunction

  // Root lives in a register, so both halves of "level 0" present it with no read latency.
  assign rd_lo[0] = root_q;
  assign rd_hi[0] = root_q;

  for (genvar l = 1; l < TreeDepth; l++) begin : g_lvl
    bram_tree_pq_level_ram #(.DataWidth(DataWidth), .Depth(2**l), .AW(IW)) u_ram (
      .CLK   (CLK),
      .we    (ram_we[l]),
      .waddr (ram_waddr),
      .wdata (ram_wdat),
      .raddr (ram_raddr),
      .rd_lo (rd_lo[l]),
      .rd_hi (rd_hi[l])
    );
  end

  always_comb begin
    state_d = state_q; cur_d = cur_q; tgt_d = tgt_q; sl_d = sl_q;
    v_d = v_q; root_d = root_q; top_d = top_q; cnt_d = cnt_q; wcnt_d = wcnt_q;
    push_d = push_q; fetch_d = fetch_q; err_d = 1'b0;
    ram_raddr = '0; wr_go = 1'b0; wr_node = '0; wr_val = '0;
    nv = '0; lval = '0; rval = '0; bval = '0; best = '0;
    lt = lev(tgt_q); lc = lev(cur_q); ls = int'(sl_q);
    cl = (lc + 1 < TreeDepth) ? lc + 1 : TreeDepth - 1;
    left   = cur_q << 1;
    right  = (cur_q << 1) | IW'(1);
    wcnt_x = IW'(wcnt_q);

    case (state_q)
      IDLE: if (bus.i_valid) begin
        case (bus.i_op)
          PUSH: if (cnt_q == CW'(QueueSize)) err_d = 1'b1;
                else begin
                  tgt_d = IW'(cnt_q) + IW'(1); cur_d = IW'(1); sl_d = '0;
                  v_d = bus.i_data; push_d = 1'b1; wcnt_d = cnt_q + 1'b1; state_d = RD;
                end
          POP: if (cnt_q == '0) err_d = 1'b1;
               else if (cnt_q == CW'(1)) begin wcnt_d = '0; state_d = DONE; end
               else begin
                 tgt_d = IW'(cnt_q); cur_d = IW'(1); push_d = 1'b0;
                 wcnt_d = cnt_q - 1'b1; state_d = FETCH_LAST;
               end
          REPLACE: if (cnt_q == '0) err_d = 1'b1;
                   else begin
                     v_d = bus.i_data; cur_d = IW'(1); push_d = 1'b0;
                     fetch_d = 1'b0; wcnt_d = cnt_q; state_d = RD;
                   end
          NOP: ;
          default: ;
        endcase
      end
      FETCH_LAST: begin
        ram_raddr = off(tgt_q) >> 1;
        fetch_d = 1'b1;
        state_d = RD;
      end
      RD: begin
        if (push_q) ram_raddr = off(cur_q) >> 1;  // the path node itself
        else begin
          ram_raddr = off(cur_q);                 // both children as one pair
          // First sift step after a pop: the last node's value lands now and becomes the carry.
          if (fetch_q) begin
            for (int l = 0; l < TreeDepth; l++) if (l == lt) v_d = tgt_q[0] ? rd_hi[l] : rd_lo[l];
            fetch_d = 1'b0;
          end
        end
        state_d = WR;
      end
      WR: if (push_q) begin
        for (int l = 0; l < TreeDepth; l++) if (l == ls) nv = cur_q[0] ? rd_hi[l] : rd_lo[l];
        wr_node = cur_q; wr_val = v_q;
        if (ls == lt) begin
          wr_go = 1'b1; state_d = DONE;
        end else begin
          if (better(IsMax, 64'(v_q), 64'(nv))) begin wr_go = 1'b1; v_d = nv; end
          sl_d = sl_q + 1'b1;
          cur_d = tgt_q >> (lt - ls - 1);
          state_d = RD;
        end
      end else begin
        // Hole-style sift: a promoted child is written up, the carry is written once at the end.
        wr_node = cur_q; wr_go = 1'b1; wr_val = v_q; state_d = DONE;
        if (left <= wcnt_x) begin
          for (int l = 0; l < TreeDepth; l++) if (l == cl) begin lval = rd_lo[l]; rval = rd_hi[l]; end
          if (right <= wcnt_x && better(IsMax, 64'(rval), 64'(lval))) begin best = right; bval = rval; end
          else begin best = left; bval = lval; end
          if (better(IsMax, 64'(bval), 64'(v_q))) begin wr_val = bval; cur_d = best; state_d = RD; end
        end
      end
      DONE: begin
        cnt_d = wcnt_q;
        top_d = (wcnt_q == '0) ? '0 : root_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ram_waddr = off(wr_node);
    ram_wdat  = wr_val;
    ram_we    = '0;
    if (wr_go && lev(wr_node) == 0) root_d = wr_val;
    for (int l = 1; l < TreeDepth; l++) ram_we[l] = wr_go && (lev(wr_node) == l);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE; cur_q <= '0; tgt_q <= '0; sl_q <= '0;
      v_q <= '0; root_q <= '0; top_q <= '0; cnt_q <= '0; wcnt_q <= '0;
      push_q <= 1'b0; fetch_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; cur_q <= cur_d; tgt_q <= tgt_d; sl_q <= sl_d;
      v_q <= v_d; root_q <= root_d; top_q <= top_d; cnt_q <= cnt_d; wcnt_q <= wcnt_d;
      push_q <= push_d; fetch_q <= fetch_d; err_q <= err_d;
    end
  end

  assign bus.i_ready     = (state_q == IDLE);
  assign bus.o_data      = top_q;
  assign bus.o_count     = cnt_q;
  assign bus.o_top_valid = (cnt_q != '0);
  assign bus.o_empty     = (cnt_q == '0);
  assign bus.o_full      = (cnt_q == CW'(QueueSize));
  assign bus.o_err       = err_q;
endmodule

// File: tb/tb_bram_tree_pq.sv
module tb_bram_tree_pq;
  import bram_tree_pq_pkg::*;

  localparam int QS      = 8;
  localparam int DW      = 32;
  localparam int CW      = $clog2(QS + 1);
  localparam int MaxBusy = 2 * CW + 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  bram_tree_pq_if #(.DataWidth(DW), .CountWidth(CW)) bm ();
  bram_tree_pq_if #(.DataWidth(DW), .CountWidth(CW)) bn ();

  bram_tree_pq #(.QueueSize(QS), .DataWidth(DW), .IsMax(1'b1)) u_max (.CLK(CLK), .RST(RST), .bus(bm));
  bram_tree_pq #(.QueueSize(QS), .DataWidth(DW), .IsMax(1'b0)) u_min (.CLK(CLK), .RST(RST), .bus(bn));

  int n_chk  = 0;
  int n_fail = 0;
  logic sel_min = 1'b0;
  logic [DW-1:0] mdl [$];

  logic [DW-1:0] s_data;
  logic [CW-1:0] s_count;
  logic s_ready, s_err, s_full, s_empty, s_tv;
  assign s_data  = sel_min ? bn.o_data      : bm.o_data;
  assign s_count = sel_min ? bn.o_count     : bm.o_count;
  assign s_ready = sel_min ? bn.i_ready     : bm.i_ready;
  assign s_err   = sel_min ? bn.o_err       : bm.o_err;
  assign s_full  = sel_min ? bn.o_full      : bm.o_full;
  assign s_empty = sel_min ? bn.o_empty     : bm.o_empty;
  assign s_tv    = sel_min ? bn.o_top_valid : bm.o_top_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: an unordered bag; the top is found by scanning for the extreme value.
  function automatic int best_idx();
    int b = 0;
    for (int i = 1; i < mdl.size(); i++)
      if (sel_min ? (mdl[i] < mdl[b]) : (mdl[i] > mdl[b])) b = i;
    return b;
  endfunction

  function automatic logic [31:0] m_top();
    if (mdl.size() == 0) return 32'd0;
    return mdl[best_idx()];
  endfunction

  task automatic drive(input logic v, input op_e op, input logic [31:0] d);
    if (sel_min) begin bn.i_valid = v; bn.i_op = op; bn.i_data = d; end
    else         begin bm.i_valid = v; bm.i_op = op; bm.i_data = d; end
  endtask

  task automatic do_op(input op_e op, input logic [31:0] d);
    logic exp_err, err_seen;
    int busy, b;
    exp_err = 1'b0;
    case (op)
      PUSH:    if (mdl.size() == QS) exp_err = 1'b1; else mdl.push_back(d);
      POP:     if (mdl.size() == 0) exp_err = 1'b1; else begin b = best_idx(); mdl.delete(b); end
      REPLACE: if (mdl.size() == 0) exp_err = 1'b1;
               else begin b = best_idx(); mdl.delete(b); mdl.push_back(d); end
      default: ;
    endcase
    @(negedge CLK); drive(1'b1, op, d);
    @(negedge CLK); drive(1'b0, NOP, '0);
    err_seen = s_err;
    busy = 0;
    while (!s_ready && busy < 4 * MaxBusy) begin @(negedge CLK); busy++; end
    chk("err_pulse", err_seen, exp_err);
    chk("busy_bound", busy <= MaxBusy, 1);
    chk("count", s_count, mdl.size());
    chk("top_data", s_data, m_top());
    chk("empty", s_empty, mdl.size() == 0);
    chk("full", s_full, mdl.size() == QS);
    chk("top_valid", s_tv, mdl.size() != 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    mdl.delete();
  endtask

  initial begin
    logic [31:0] fill [8];
    logic [31:0] exp_seq [8];
    int r;
    fill    = '{8, 6, 4, 2, 9, 5, 3, 1};
    exp_seq = '{9, 8, 6, 5, 4, 3, 2, 1};
    bm.i_valid = 1'b0; bm.i_op = NOP; bm.i_data = '0;
    bn.i_valid = 1'b0; bn.i_op = NOP; bn.i_data = '0;

    // Reset state
    do_reset();
    chk("rst_count", s_count, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_top_valid", s_tv, 0);
    chk("rst_data", s_data, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_err", s_err, 0);

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 8; i++) do_op(PUSH, fill[i]);
    chk("full_top", s_data, 9);
    do_op(PUSH, 7);
    for (int i = 0; i < 8; i++) begin
      chk("pop_seq", s_data, exp_seq[i]);
      do_op(POP, 0);
    end
    chk("drained_empty", s_empty, 1);
    do_op(POP, 0);

    // Replace on full, then drain to see the whole heap order
    for (int i = 0; i < 8; i++) do_op(PUSH, fill[i]);
    do_op(REPLACE, 7);
    chk("replace7_top", s_data, 8);
    do_op(REPLACE, 100);
    chk("replace100_top", s_data, 100);
    for (int i = 0; i < 8; i++) do_op(POP, 0);
    do_op(REPLACE, 5);
    chk("replace_empty_count", s_count, 0);

    // Random traffic with many ties
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      do_op(NOP, $urandom);
      else if (r <= 4) do_op(PUSH, (r == 4) ? $urandom : $urandom_range(0, 15));
      else if (r <= 7) do_op(POP, 0);
      else             do_op(REPLACE, $urandom_range(0, 15));
    end

    // Reset abandons an in-flight replace
    do_reset();
    for (int i = 0; i < 8; i++) do_op(PUSH, $urandom_range(0, 200));
    @(negedge CLK); drive(1'b1, REPLACE, 50);
    @(negedge CLK); drive(1'b0, NOP, '0);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
    chk("midop_count", s_count, 0);
    chk("midop_ready", s_ready, 1);
    chk("midop_empty", s_empty, 1);
    RST = 1'b0;
    mdl.delete();
    do_op(PUSH, 3);
    chk("midop_push3", s_data, 3);

    // Min-ordered instance, emptied by the reset above
    sel_min = 1'b1;
    do_reset();
    do_op(PUSH, 8); do_op(PUSH, 6); do_op(PUSH, 4); do_op(PUSH, 6);
    chk("min_top", s_data, 4);
    do_op(POP, 0);
    chk("min_pop1", s_data, 6);
    do_op(POP, 0);
    chk("min_pop2_tie", s_data, 6);
    chk("min_count", s_count, 2);
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      do_op(NOP, 0);
      else if (r <= 4) do_op(PUSH, $urandom_range(0, 15));
      else if (r <= 7) do_op(POP, 0);
      else             do_op(REPLACE, $urandom_range(0, 15));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_tree_pq.md
Name: bram_tree_pq

Overview:
- Parametrised successor to the BRAM-per-level tree queue: a heap-ordered binary tree with one memory per level, L = TreeDepth levels.
- Adds push-only, pop-only and replace operations behind a ready/valid handshake, plus occupancy count, full/empty flags, an error pulse and selectable max/min ordering.
- Sits between a scheduler front end and consumers that need the highest- (or lowest-) priority item each cycle.

Parameters:
- QueueSize, 8, maximum stored items; full when count == QueueSize.
- DataWidth, 32, item width in bits.
- IsMax, 1, 1 = max-heap (o_data is the largest item), 0 = min-heap.
- TreeDepth, $clog2(QueueSize+1), derived levels; level l holds 2^l nodes.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- i_valid  in  1  operation request.
- i_op  in  2  00 nop, 01 push, 10 pop, 11 replace (pop top, then push i_data).
- i_data  in  DataWidth  item for push/replace.
- i_ready  out  1  high when idle; an op is accepted on the edge where i_valid && i_ready.
- o_data  out  DataWidth  current top item; 0 when empty.
- o_top_valid  out  1  count != 0.
- o_count  out  $clog2(QueueSize+1)  stored items.
- o_full  out  1  count == QueueSize.
- o_empty  out  1  count == 0.
- o_err  out  1  one-cycle pulse when an accepted op is illegal.

Behaviour:
- Reset:
  - o_data=0, o_count=0, o_empty=1, o_full=0, o_top_valid=0, o_err=0, i_ready=1, FSM=IDLE.
  - Memory contents are don't-care; occupancy is tracked by count only.
  - RST has priority over any in-flight op, which is abandoned.
- Illegal ops: push when full, pop or replace when empty.
  - Accepted; no state change; o_err=1 the next cycle; i_ready stays high.
- nop is accepted with no effect.
- Node addressing: 1-based heap index n; level = floor(log2 n); offset = n - 2^level.
- FSM states: IDLE, FETCH_LAST, RD, WR, DONE. Each level step is RD (issue a 1-cycle BRAM read of the path node or both children) then WR (compare and write back).
- Push:
  - Target index t = count+1. Walk top-down along the path to t, carrying the value.
  - At each level, the better of (carried, node) stays and the other is carried down.
  - At level(t), write the carried value. count+1.
- Pop:
  - count==1: no walk; count=0 directly.
  - Otherwise FETCH_LAST reads node count, moves it to the root, decrements count, then sifts down from the root. Each step swaps with the better child only if that child is strictly better. Stop at a leaf or when no swap occurs.
- Replace: write i_data to the root and sift down; count unchanged.
- Ties: an existing node wins; equal values are never swapped.
- "Better" means > when IsMax=1 and < when IsMax=0, unsigned compare.
- Completion:
  - i_ready drops the cycle after acceptance.
  - DONE updates o_data, o_count and the flags together; i_ready rises in that same cycle.
  - Worst-case busy time is 2*TreeDepth+2 cycles.
  - Outputs never show intermediate tree states.
- Read-during-write on the same level RAM address returns the old data. The FSM never relies on it.

Decomposition:
- Package bram_tree_pq_pkg: op_e enum (NOP, PUSH, POP, REPLACE), state_e enum, and a better() compare function parametrised by IsMax.
- Sub-module bram_tree_pq_level_ram: simple dual-port, one write port and one read port, 1-cycle registered read, depth 2^l, generated once per level. The root level may be a register.

Test Plan:
- Reset: RST high 2 cycles -> o_count=0, o_empty=1, o_top_valid=0, o_data=0, i_ready=1.
- Push 8,6,4,2,9,5,3,1 -> o_data=9, o_count=8, o_full=1. Then push 7 -> o_err pulse, o_count stays 8, o_data=9.
- From that full state, 8 pops -> o_data before each pop reads 9,8,6,5,4,3,2,1. Then o_empty=1; a further pop -> o_err pulse.
- Full state again, replace 7 -> o_data=8, count 8. Replace 100 -> o_data=100. Replace on an empty queue -> o_err, count 0.
- IsMax=0 instance: push 8,6,4,6 -> o_data=4. Pop -> o_data=6. Pop -> o_data=6 (tie handled). o_count=2.
- Reset mid-op: accept replace 50 on the full queue, assert RST 2 cycles later -> next cycle o_count=0, i_ready=1. A subsequent push 3 -> o_data=3.
